id_stage_pipe: RTL and testbench



---
 rtl/id_stage_pipe_pkg.sv | 51 +++++
 rtl/id_stage_pipe_if.sv | 47 ++++
 rtl/id_stage_pipe_regfile.sv | 44 ++++
 rtl/id_stage_pipe.sv | 110 +++++++++++
 tb/tb_id_stage_pipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pipe_pkg.sv
// RISC-V decode constants and opcode classification helpers
// shared by the decode stage and its register file.
package rv_pkg;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_sel_e;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == LUI || op == AUIPC || op == JAL);
    endfunction

    // only R, S and B formats carry a real rs2
    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OP || op == STORE || op == BRANCH;
    endfunction

    function automatic logic uses_rd(input logic [6:0] op);
        return !(op == STORE || op == BRANCH);
    endfunction

    function automatic imm_sel_e imm_sel(input logic [6:0] op);
        case (op)
            LOAD, OP_IMM, JALR, MISC_MEM, SYSTEM: return IMM_I;
            STORE:       return IMM_S;
            BRANCH:      return IMM_B;
            LUI, AUIPC:  return IMM_U;
            JAL:         return IMM_J;
            default:     return IMM_NONE;
        endcase
    endfunction

    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM,
            LUI, AUIPC, MISC_MEM, SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/id_stage_pipe_if.sv
// IF/ID input, write-back, flush and ID/EX output bundle
// for the decode stage.
interface id_stage_pipe_if #(parameter int XLEN = 32);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] pc_plus4_i;
    logic [31:0]     instr_i;
    logic            wb_reg_we_i;
    logic [4:0]      wb_rd_addr_i;
    logic [XLEN-1:0] wb_rd_data_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] rs1_data_o;
    logic [XLEN-1:0] rs2_data_o;
    logic [XLEN-1:0] imm_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic [4:0]      rs1_addr_o;
    logic [4:0]      rs2_addr_o;
    logic [4:0]      rd_addr_o;
    logic [6:0]      opcode_o;
    logic [2:0]      funct3_o;
    logic [6:0]      funct7_o;
    logic            illegal_o;

    modport slave (
        input  in_valid_i, pc_i, pc_plus4_i, instr_i,
        input  wb_reg_we_i, wb_rd_addr_i, wb_rd_data_i,
        input  flush_i, out_ready_i,
        output in_ready_o, out_valid_o,
        output rs1_data_o, rs2_data_o, imm_o, pc_o, pc_plus4_o,
        output rs1_addr_o, rs2_addr_o, rd_addr_o,
        output opcode_o, funct3_o, funct7_o, illegal_o
    );

    modport master (
        output in_valid_i, pc_i, pc_plus4_i, instr_i,
        output wb_reg_we_i, wb_rd_addr_i, wb_rd_data_i,
        output flush_i, out_ready_i,
        input  in_ready_o, out_valid_o,
        input  rs1_data_o, rs2_data_o, imm_o, pc_o, pc_plus4_o,
        input  rs1_addr_o, rs2_addr_o, rd_addr_o,
        input  opcode_o, funct3_o, funct7_o, illegal_o
    );
endinterface

// File: rtl/id_stage_pipe_regfile.sv
// Two-read one-write register file with write-back bypass;
// in 16-entry mode writes and reads above x15 are ignored.
module regfile
    import rv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            wr_en;

    function automatic logic in_range(input logic [4:0] a);
        return (NUM_REGS == 32) || !a[4];
    endfunction

    assign wr_en = we && waddr != 5'd0 && in_range(waddr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0 || !in_range(raddr1)) ? '0 :
                    (wr_en && waddr == raddr1) ? wdata :
                    regs[raddr1[AW-1:0]];
    assign rdata2 = (raddr2 == 5'd0 || !in_range(raddr2)) ? '0 :
                    (wr_en && waddr == raddr2) ? wdata :
                    regs[raddr2[AW-1:0]];
endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with register file, immediate generation,
// load-use stall, flush and integrated ID/EX register.
module id_stage_pipe
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NUM_REGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic            clk,
    input logic            rst,
    id_stage_pipe_if.slave bus
);
    logic [31:0]     instr;
    logic [6:0]      op;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    imm_sel_e        sel;
    logic            reg_bad, illegal, hazard, accept;

    assign instr = bus.instr_i;
    assign op    = instr[6:0];
    assign rd    = instr[11:7];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign sel   = imm_sel(op);

    always_comb begin
        imm32 = '0;
        unique case (sel)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    // RV32E: any index reaching x16..x31 in a used field is illegal
    assign reg_bad = (NUM_REGS == 16) &&
                     ((uses_rs1(op) && rs1[4]) ||
                      (uses_rs2(op) && rs2[4]) ||
                      (uses_rd(op)  && rd[4]));
    assign illegal = !legal_op(op) || reg_bad;

    assign hazard = bus.out_valid_o && bus.opcode_o == LOAD &&
                    bus.rd_addr_o != 5'd0 &&
                    ((uses_rs1(op) && bus.rd_addr_o == rs1) ||
                     (uses_rs2(op) && bus.rd_addr_o == rs2));

    assign bus.in_ready_o = !bus.flush_i && !hazard &&
                            (!bus.out_valid_o || bus.out_ready_i);
    assign accept = bus.in_valid_i && bus.in_ready_o;

    regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_reg_we_i),
        .waddr  (bus.wb_rd_addr_i),
        .wdata  (bus.wb_rd_data_i),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid_o <= 1'b0;
            bus.rs1_data_o  <= '0;
            bus.rs2_data_o  <= '0;
            bus.imm_o       <= '0;
            bus.pc_o        <= RESET_PC;
            bus.pc_plus4_o  <= RESET_PC + XLEN'(4);
            bus.rs1_addr_o  <= '0;
            bus.rs2_addr_o  <= '0;
            bus.rd_addr_o   <= '0;
            bus.opcode_o    <= '0;
            bus.funct3_o    <= '0;
            bus.funct7_o    <= '0;
            bus.illegal_o   <= 1'b0;
        end else begin
            if (bus.flush_i)          bus.out_valid_o <= 1'b0;
            else if (accept)          bus.out_valid_o <= 1'b1;
            else if (bus.out_ready_i) bus.out_valid_o <= 1'b0;
            // payload moves only with an accepted instruction
            if (accept) begin
                bus.rs1_data_o <= rs1_data;
                bus.rs2_data_o <= rs2_data;
                bus.imm_o      <= imm;
                bus.pc_o       <= bus.pc_i;
                bus.pc_plus4_o <= bus.pc_plus4_i;
                bus.rs1_addr_o <= rs1;
                bus.rs2_addr_o <= rs2;
                bus.rd_addr_o  <= rd;
                bus.opcode_o   <= op;
                bus.funct3_o   <= instr[14:12];
                bus.funct7_o   <= instr[31:25];
                bus.illegal_o  <= illegal;
            end
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: vector table, directed
// pipeline corner cases, random traffic against a reference model.
module tb_id_stage_pipe;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32)) bus ();
    id_stage_pipe_if #(.XLEN(32)) bus_e ();

    id_stage_pipe #(.XLEN(32), .NUM_REGS(32), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    id_stage_pipe #(.XLEN(32), .NUM_REGS(16), .RESET_PC(32'h0)) dut_e (
        .clk (clk),
        .rst (rst),
        .bus (bus_e)
    );

    typedef struct packed {
        logic [31:0] rs1d, rs2d, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ill;
    } pay_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic        ill;
        logic [4:0]  rd;
    } vec_t;

    vec_t        tbl [11];
    logic [31:0] mregs [32];
    pay_t        mpay;
    logic        mvalid;

    task automatic chk(input string n, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic ordy, input logic fl,
                         input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        bus.in_valid_i   = v;
        bus.instr_i      = ins;
        bus.out_ready_i  = ordy;
        bus.flush_i      = fl;
        bus.wb_reg_we_i  = we;
        bus.wb_rd_addr_i = wa;
        bus.wb_rd_data_i = wd;
    endtask

    task automatic drive_e(input logic v, input logic [31:0] ins,
                           input logic we, input logic [4:0] wa,
                           input logic [31:0] wd);
        bus_e.in_valid_i   = v;
        bus_e.instr_i      = ins;
        bus_e.wb_reg_we_i  = we;
        bus_e.wb_rd_addr_i = wa;
        bus_e.wb_rd_data_i = wd;
    endtask

    function automatic pay_t dut_pay();
        pay_t p;
        p.rs1d = bus.rs1_data_o;
        p.rs2d = bus.rs2_data_o;
        p.imm  = bus.imm_o;
        p.pc   = bus.pc_o;
        p.pc4  = bus.pc_plus4_o;
        p.rs1  = bus.rs1_addr_o;
        p.rs2  = bus.rs2_addr_o;
        p.rd   = bus.rd_addr_o;
        p.op   = bus.opcode_o;
        p.f3   = bus.funct3_o;
        p.f7   = bus.funct7_o;
        p.ill  = bus.illegal_o;
        return p;
    endfunction

    // immediates rebuilt from the ISA bit layout using arithmetic shifts
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic signed [31:0] s;
        s = $signed(ins);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73:
                return 32'(s >>> 20);
            7'h23:
                return (32'(s >>> 25) << 5) | 32'(ins[11:7]);
            7'h63:
                return (32'(s >>> 31) << 12) | (32'(ins[7]) << 11) |
                       (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            7'h37, 7'h17:
                return ins & 32'hFFFF_F000;
            7'h6F:
                return (32'(s >>> 31) << 20) | (32'(ins[19:12]) << 12) |
                       (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            default:
                return 32'h0;
        endcase
    endfunction

    function automatic logic ref_legal(input logic [6:0] op);
        return op inside {7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33,
                          7'h13, 7'h37, 7'h17, 7'h0F, 7'h73};
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a,
                                             input logic we,
                                             input logic [4:0] wa,
                                             input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return mregs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mvalid   = 1'b0;
        mpay     = '0;
        mpay.pc  = RST_PC;
        mpay.pc4 = RST_PC + 32'd4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins, wd, pc;
        logic [6:0]  ops [12];
        logic [6:0]  op;
        logic [4:0]  wa, r1, r2;
        logic        iv, ordy, fl, we, hz, u1, u2, rdy;

        tbl[0]  = '{32'hFFF08113, 32'hFFFFFFFF, 1'b0, 5'd2};
        tbl[1]  = '{32'h123452B7, 32'h12345000, 1'b0, 5'd5};
        tbl[2]  = '{32'h0020A423, 32'h00000008, 1'b0, 5'd8};
        tbl[3]  = '{32'hFE000EE3, 32'hFFFFFFFC, 1'b0, 5'd29};
        tbl[4]  = '{32'h001000EF, 32'h00000800, 1'b0, 5'd1};
        tbl[5]  = '{32'h0000007F, 32'h00000000, 1'b1, 5'd0};
        tbl[6]  = '{32'h002081B3, 32'h00000000, 1'b0, 5'd3};
        tbl[7]  = '{32'h00000073, 32'h00000000, 1'b0, 5'd0};
        tbl[8]  = '{32'h0000000B, 32'h00000000, 1'b1, 5'd0};
        tbl[9]  = '{32'hFFFFF097, 32'hFFFFF000, 1'b0, 5'd1};
        tbl[10] = '{32'hFF8100E7, 32'hFFFFFFF8, 1'b0, 5'd1};

        ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33,
                7'h13, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h7F};

        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        drive_e(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.pc_i = 32'h200;
        bus.pc_plus4_i = 32'h204;
        bus_e.pc_i = 32'h0;
        bus_e.pc_plus4_i = 32'h4;
        bus_e.flush_i = 1'b0;
        bus_e.out_ready_i = 1'b1;
        #12;
        rst = 1'b0;
        #1;

        chk("rst_valid", bus.out_valid_o, 1'b0);
        chk("rst_pc", bus.pc_o, RST_PC);
        chk("rst_pc4", bus.pc_plus4_o, RST_PC + 32'd4);
        chk("rst_ready", bus.in_ready_o, 1'b1);
        chk("rst_imm", bus.imm_o, 32'h0);

        for (int i = 0; i < 11; i++) begin
            pc = 32'h1000 + 32'(4 * i);
            bus.pc_i = pc;
            bus.pc_plus4_i = pc + 32'd4;
            drive(1'b1, tbl[i].instr, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
            tick();
            chk("tbl_valid", bus.out_valid_o, 1'b1);
            chk("tbl_imm", bus.imm_o, tbl[i].imm);
            chk("tbl_illegal", bus.illegal_o, tbl[i].ill);
            chk("tbl_rd", bus.rd_addr_o, tbl[i].rd);
            chk("tbl_pc", bus.pc_o, pc);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();

        drive(1'b1, 32'hFFF08113, 1'b1, 1'b0, 1'b1, 5'd1, 32'h10);
        tick();
        chk("byp_rs1", bus.rs1_data_o, 32'h10);
        chk("byp_imm", bus.imm_o, 32'hFFFFFFFF);
        chk("byp_rd", bus.rd_addr_o, 5'd2);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();

        drive(1'b1, 32'h00002183, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b1, 32'h00318233, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        #1 chk("lu_stall_ready", bus.in_ready_o, 1'b0);
        tick();
        chk("lu_bubble", bus.out_valid_o, 1'b0);
        drive(1'b1, 32'h00318233, 1'b1, 1'b0, 1'b1, 5'd3, 32'h55);
        #1 chk("lu_resume_ready", bus.in_ready_o, 1'b1);
        tick();
        chk("lu_add_valid", bus.out_valid_o, 1'b1);
        chk("lu_add_op", bus.opcode_o, 7'h33);
        chk("lu_add_rs1", bus.rs1_data_o, 32'h55);
        chk("lu_add_rs2", bus.rs2_data_o, 32'h55);

        drive(1'b1, 32'h00002003, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b1, 32'h00000233, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        #1 chk("lu_x0_ready", bus.in_ready_o, 1'b1);
        tick();
        chk("lu_x0_valid", bus.out_valid_o, 1'b1);
        chk("lu_x0_op", bus.opcode_o, 7'h33);

        drive(1'b1, 32'h00700293, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", bus.in_ready_o, 1'b0);
            tick();
            chk("bp_valid", bus.out_valid_o, 1'b1);
            chk("bp_hold_rd", bus.rd_addr_o, 5'd4);
            chk("bp_hold_op", bus.opcode_o, 7'h33);
        end
        drive(1'b1, 32'h00700293, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("bp_adv1_rd", bus.rd_addr_o, 5'd5);
        chk("bp_adv1_imm", bus.imm_o, 32'd7);
        drive(1'b1, 32'h00900313, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("bp_adv2_rd", bus.rd_addr_o, 5'd6);
        chk("bp_adv2_imm", bus.imm_o, 32'd9);

        drive(1'b1, 32'h00002183, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b1, 32'h00318233, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        #1 chk("fl_stall_ready", bus.in_ready_o, 1'b0);
        tick();
        chk("fl_stall_valid", bus.out_valid_o, 1'b0);
        drive(1'b1, 32'h00318233, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        #1 chk("fl_kept_ready", bus.in_ready_o, 1'b1);
        tick();
        chk("fl_kept_valid", bus.out_valid_o, 1'b1);
        chk("fl_kept_rd", bus.rd_addr_o, 5'd4);
        drive(1'b1, 32'h00700293, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        chk("fl_drop_valid", bus.out_valid_o, 1'b0);
        chk("fl_drop_rd", bus.rd_addr_o, 5'd4);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();

        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            op  = ($urandom_range(0, 3) == 0) ? 7'h03
                                              : ops[$urandom_range(0, 11)];
            ins = $urandom;
            ins[6:0]   = op;
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 11) == 0);
            we   = ($urandom_range(0, 1) == 1);
            wa   = 5'($urandom_range(0, 7));
            wd   = $urandom;
            pc   = $urandom;
            bus.pc_i = pc;
            bus.pc_plus4_i = pc + 32'd4;
            drive(iv, ins, ordy, fl, we, wa, wd);
            #1;
            r1 = ins[19:15];
            r2 = ins[24:20];
            u1 = !(op inside {7'h37, 7'h17, 7'h6F});
            u2 = op inside {7'h33, 7'h23, 7'h63};
            hz = mvalid && mpay.op == 7'h03 && mpay.rd != 5'd0 &&
                 ((u1 && mpay.rd == r1) || (u2 && mpay.rd == r2));
            rdy = !fl && !hz && (!mvalid || ordy);
            chk("rnd_ready", bus.in_ready_o, rdy);
            if (fl) begin
                mvalid = 1'b0;
            end else if (iv && rdy) begin
                mvalid   = 1'b1;
                mpay.rs1d = ref_read(r1, we, wa, wd);
                mpay.rs2d = ref_read(r2, we, wa, wd);
                mpay.imm  = ref_imm(ins);
                mpay.pc   = pc;
                mpay.pc4  = pc + 32'd4;
                mpay.rs1  = r1;
                mpay.rs2  = r2;
                mpay.rd   = ins[11:7];
                mpay.op   = op;
                mpay.f3   = ins[14:12];
                mpay.f7   = ins[31:25];
                mpay.ill  = !ref_legal(op);
            end else if (ordy) begin
                mvalid = 1'b0;
            end
            if (we && wa != 5'd0) mregs[wa] = wd;
            tick();
            chk("rnd_valid", bus.out_valid_o, mvalid);
            chk("rnd_payload", dut_pay(), mpay);
        end

        drive(1'b1, 32'h00700293, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid_o, 1'b0);
        chk("mid_rst_pc", bus.pc_o, RST_PC);
        rst = 1'b0;
        drive(1'b1, 32'h00028033, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("mid_rst_x5", bus.rs1_data_o, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

        drive_e(1'b1, 32'h002088B3, 1'b0, 5'd0, 32'h0);
        tick();
        chk("e_valid", bus_e.out_valid_o, 1'b1);
        chk("e_illegal_rd17", bus_e.illegal_o, 1'b1);
        drive_e(1'b1, 32'h002081B3, 1'b0, 5'd0, 32'h0);
        tick();
        chk("e_legal_add", bus_e.illegal_o, 1'b0);
        drive_e(1'b0, 32'h0, 1'b1, 5'd20, 32'hDEAD);
        tick();
        drive_e(1'b0, 32'h0, 1'b1, 5'd5, 32'h7);
        tick();
        for (int i = 0; i < 16; i++) begin
            ins = 32'h33 | (32'(i) << 15);
            drive_e(1'b1, ins, 1'b0, 5'd0, 32'h0);
            tick();
            chk("e_reg_read", bus_e.rs1_data_o, (i == 5) ? 32'h7 : 32'h0);
        end
        drive_e(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
